// File: rtl/lfsr_pkg.sv
// ============================================================================
// lfsr_pkg : checker FSM states and the shared Galois LFSR step function
// Revision : 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // Bit-identical to the generator's run_L step; tap[0] feeds bit 7.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q, input logic [6:0] tap);
        logic       t;
        logic [7:0] n;
        t    = q[7];
        n[0] = t;
        for (int i = 1; i <= 6; i++) begin
            n[i] = q[i-1] ^ (tap[7-i] & t);
        end
        n[7] = q[6] ^ (tap[0] & t);
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_pattern_checker_popcount8.sv
// ============================================================================
// popcount8 : combinational count of set bits in an 8-bit word
// Revision  : 1.0
// ============================================================================
`default_nettype none

module popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'd0, data_i[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/lfsr_pattern_checker.sv
// ============================================================================
// lfsr_pattern_checker : reads back a block of LFSR words, reports mismatches,
//                        first failing address and total Hamming distance
// Revision             : 1.0
// ============================================================================
`default_nettype none

module lfsr_pattern_checker
    import lfsr_pkg::*;
#(
    parameter int AW  = 8,
    parameter int HDW = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [AW-1:0]  base_addr,
    input  logic [7:0]     word_count,
    input  logic [6:0]     tap_loc,
    output logic [AW-1:0]  mem_addr,
    input  logic [7:0]     mem_rdata,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [7:0]     err_count,
    output logic [AW-1:0]  first_err_addr,
    output logic [HDW-1:0] hd_total
);

    chk_state_t     state_q, state_d;
    logic [6:0]     tap_q, tap_d;
    logic [7:0]     exp_q, exp_d;
    logic [8:0]     rem_q, rem_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     err_q, err_d;
    logic [AW-1:0]  first_q, first_d;
    logic [HDW-1:0] hd_q, hd_d;
    logic           pass_q, pass_d;

    logic [7:0]     diff;
    logic [3:0]     diff_cnt;

    assign diff = exp_q ^ mem_rdata;

    popcount8 u_popcount8 (
        .data_i  (diff),
        .count_o (diff_cnt)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        err_d   = err_q;
        first_d = first_q;
        hd_d    = hd_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tap_d   = tap_loc;
                    addr_d  = base_addr;
                    rem_d   = (word_count == 8'd0) ? 9'd256 : {1'b0, word_count};
                    err_d   = 8'd0;
                    first_d = '0;
                    hd_d    = '0;
                    pass_d  = 1'b1;
                    state_d = SEED;
                end
            end
            SEED: begin
                exp_d   = lfsr_step(mem_rdata, tap_q);
                addr_d  = addr_q + AW'(1);
                rem_d   = rem_q - 9'd1;
                state_d = (rem_q == 9'd1) ? DONE : CHECK;
            end
            CHECK: begin
                // pass_q still high means no mismatch yet in this run
                if (diff != 8'd0) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (pass_q) begin
                        first_d = addr_q;
                    end
                    pass_d = 1'b0;
                end
                hd_d    = hd_q + HDW'(diff_cnt);
                exp_d   = lfsr_step(exp_q, tap_q);
                addr_d  = addr_q + AW'(1);
                rem_d   = rem_q - 9'd1;
                state_d = (rem_q == 9'd1) ? DONE : CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tap_q   <= 7'd0;
            exp_q   <= 8'd0;
            rem_q   <= 9'd0;
            addr_q  <= '0;
            err_q   <= 8'd0;
            first_q <= '0;
            hd_q    <= '0;
            pass_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            first_q <= first_d;
            hd_q    <= hd_d;
            pass_q  <= pass_d;
        end
    end

    assign mem_addr       = addr_q;
    assign busy           = (state_q == SEED) || (state_q == CHECK);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign hd_total       = hd_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_pattern_checker.sv
// ============================================================================
// tb_lfsr_pattern_checker : directed runs with a result scoreboard checked on done
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_pattern_checker;

    localparam int AW  = 8;
    localparam int HDW = 11;

    logic           clk;
    logic           reset;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [7:0]     word_count;
    logic [6:0]     tap_loc;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_rdata;
    logic           busy;
    logic           done;
    logic           pass;
    logic [7:0]     err_count;
    logic [AW-1:0]  first_err_addr;
    logic [HDW-1:0] hd_total;

    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    lfsr_pattern_checker #(.AW(AW), .HDW(HDW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .tap_loc        (tap_loc),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .hd_total       (hd_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [7:0]     err;
        logic [AW-1:0]  first;
        logic [HDW-1:0] hd;
        logic           pass;
        int             done_edge;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_edge", edge_cnt, e.done_edge);
                check("err_count", {24'd0, err_count}, {24'd0, e.err});
                check("first_err_addr", {24'd0, first_err_addr}, {24'd0, e.first});
                check("hd_total", {21'd0, hd_total}, {21'd0, e.hd});
                check("pass", {31'd0, pass}, {31'd0, e.pass});
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd1);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_first", {24'd0, first_err_addr}, 32'd0);
        check("rst_hd", {21'd0, hd_total}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
    endtask

    // One run; glitch_k >= 0 pulses a conflicting start while the run is busy.
    task automatic run(input logic [7:0] base, input logic [7:0] cnt, input logic [6:0] tap,
                       input logic [7:0] e_err, input logic [7:0] e_first,
                       input logic [HDW-1:0] e_hd, input logic e_pass, input int glitch_k);
        int   n;
        exp_t e;
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        @(negedge clk);
        base_addr  = base;
        word_count = cnt;
        tap_loc    = tap;
        start      = 1'b1;
        e.err       = e_err;
        e.first     = e_first;
        e.hd        = e_hd;
        e.pass      = e_pass;
        e.done_edge = edge_cnt + 1 + n;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= n; k++) begin
            logic [7:0] ea;
            ea = base + k[7:0];
            check("mem_addr", {24'd0, mem_addr}, {24'd0, ea});
            if (k == glitch_k) begin
                start      = 1'b1;
                base_addr  = 8'h77;
                word_count = 8'd2;
                tap_loc    = 7'h7F;
            end else begin
                start = 1'b0;
            end
            if (k < n) @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_t1();
        mem[10] = 8'h01; mem[11] = 8'h02; mem[12] = 8'h04; mem[13] = 8'h08; mem[14] = 8'h10;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; tap_loc = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;

        // 1: clean walking-one run
        load_t1();
        run(8'd10, 8'd5, 7'h01, 8'd0, 8'd0, 11'd0, 1'b1, -1);
        // 2: single-bit corruption at address 12
        mem[12] = 8'h05;
        run(8'd10, 8'd5, 7'h01, 8'd1, 8'd12, 11'd1, 1'b0, -1);
        // 3: address wrap with tap feedback 80 -> 81
        mem[8'hFE] = 8'h40; mem[8'hFF] = 8'h80; mem[8'h00] = 8'h81;
        run(8'hFE, 8'd3, 7'h01, 8'd0, 8'd0, 11'd0, 1'b1, -1);
        // 4: seed only
        mem[8'h30] = 8'h5A;
        run(8'h30, 8'd1, 7'h3C, 8'd0, 8'd0, 11'd0, 1'b1, -1);
        // 5: 256 words, zero seed, every checked word all-ones
        mem[0] = 8'h00;
        for (int i = 1; i < 256; i++) mem[i] = 8'hFF;
        run(8'h00, 8'd0, 7'h55, 8'd255, 8'd1, 11'd2040, 1'b0, -1);

        // 6a: async reset in the third CHECK cycle of an erroring run
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'h01;
        @(negedge clk);
        base_addr = 8'h40; word_count = 8'd10; tap_loc = 7'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_err", {24'd0, err_count}, 32'd2);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 6b: start and tap changes while busy are ignored
        load_t1();
        run(8'd10, 8'd5, 7'h01, 8'd0, 8'd0, 11'd0, 1'b1, 2);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL pending_runs: got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
